// File: rtl/sha256_stream_padder.sv
// SHA-256 message padder: packs a byte stream of IN_W-bit words into 512-bit blocks and appends
// the 0x80 marker, zero fill and 64-bit big-endian bit length, spilling into an extra block if needed.
module sha256_stream_padder #(
    parameter int IN_W  = 32,
    parameter int CNT_W = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [IN_W-1:0]           in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_last,
    input  logic [$clog2(IN_W/8):0]   in_bytes,
    output logic [511:0]              out_block,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_last,
    output logic [CNT_W-1:0]          out_blk_idx,
    output logic [63:0]               msg_bits
);

    localparam int WB = IN_W / 8;
    localparam int NW = 512 / IN_W;
    localparam int BW = $clog2(IN_W / 8) + 1;

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_EXTRA = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             state_q;
    logic [6:0]         ptr_q;
    logic [511:0]       blk_q;
    logic [63:0]        bits_q;
    logic [CNT_W-1:0]   idx_q;
    logic               valid_q;
    logic               last_q;
    logic               rdy_q;
    logic               pad80_q;

    logic [6:0]         n_s;
    logic [6:0]         end_s;
    logic [63:0]        bits_s;
    logic [IN_W-1:0]    word_s;
    logic [511:0]       fill_s;
    logic [511:0]       pad_s;
    logic [511:0]       tail_s;

    assign in_ready    = rdy_q;
    assign out_block   = blk_q;
    assign out_valid   = valid_q;
    assign out_last    = last_q;
    assign out_blk_idx = idx_q;
    assign msg_bits    = bits_q;

    // Byte count of the offered word, masked word, merged block and its padded form
    always_comb begin
        n_s = 7'(WB);
        if (in_last) begin
            if (in_bytes > BW'(WB)) begin
                n_s = 7'(WB);
            end else begin
                n_s = 7'(in_bytes);
            end
        end else begin
            n_s = 7'(WB);
        end
        end_s  = ptr_q + n_s;
        bits_s = bits_q + {54'd0, n_s, 3'd0};

        word_s = '0;
        for (int j = 0; j < WB; j++) begin
            if (7'(j) < n_s) begin
                word_s[IN_W-1-8*j -: 8] = in_data[IN_W-1-8*j -: 8];
            end else begin
                word_s[IN_W-1-8*j -: 8] = 8'h00;
            end
        end

        // ptr is always word-aligned, so the word lands in exactly one slot
        fill_s = blk_q;
        for (int k = 0; k < NW; k++) begin
            if (ptr_q == 7'(k * WB)) begin
                fill_s[511-IN_W*k -: IN_W] = word_s;
            end else begin
                fill_s[511-IN_W*k -: IN_W] = blk_q[511-IN_W*k -: IN_W];
            end
        end

        pad_s = fill_s;
        for (int i = 0; i < 64; i++) begin
            if (end_s == 7'(i)) begin
                pad_s[511-8*i -: 8] = 8'h80;
            end else begin
                pad_s[511-8*i -: 8] = fill_s[511-8*i -: 8];
            end
        end
        if (end_s <= 7'd55) begin
            pad_s[63:0] = bits_s;
        end else begin
            pad_s[63:0] = pad_s[63:0];
        end

        tail_s = {(pad80_q ? 8'h80 : 8'h00), 440'd0, bits_q};
    end

    // Padder FSM with registered handshake and block outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FILL;
            ptr_q   <= 7'd0;
            blk_q   <= 512'd0;
            bits_q  <= 64'd0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            rdy_q   <= 1'b0;
            pad80_q <= 1'b0;
        end else begin
            case (state_q)
                S_FILL: begin
                    if (valid_q) begin
                        if (out_ready) begin
                            valid_q <= 1'b0;
                            blk_q   <= 512'd0;
                            idx_q   <= idx_q + 1'b1;
                            rdy_q   <= 1'b1;
                        end else begin
                            rdy_q   <= 1'b0;
                        end
                    end else if (in_valid && rdy_q) begin
                        bits_q <= bits_s;
                        if (in_last) begin
                            blk_q   <= pad_s;
                            valid_q <= 1'b1;
                            rdy_q   <= 1'b0;
                            ptr_q   <= end_s;
                            pad80_q <= (end_s == 7'd64);
                            if (end_s <= 7'd55) begin
                                last_q  <= 1'b1;
                                state_q <= S_DONE;
                            end else begin
                                last_q  <= 1'b0;
                                state_q <= S_EXTRA;
                            end
                        end else if (end_s == 7'd64) begin
                            blk_q   <= fill_s;
                            valid_q <= 1'b1;
                            rdy_q   <= 1'b0;
                            ptr_q   <= 7'd0;
                        end else begin
                            blk_q   <= fill_s;
                            rdy_q   <= 1'b1;
                            ptr_q   <= end_s;
                        end
                    end else begin
                        rdy_q <= 1'b1;
                    end
                end
                S_EXTRA: begin
                    rdy_q <= 1'b0;
                    if (out_ready) begin
                        blk_q   <= tail_s;
                        last_q  <= 1'b1;
                        idx_q   <= idx_q + 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        state_q <= S_EXTRA;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        blk_q   <= 512'd0;
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                        ptr_q   <= 7'd0;
                        bits_q  <= 64'd0;
                        idx_q   <= '0;
                        pad80_q <= 1'b0;
                        rdy_q   <= 1'b1;
                        state_q <= S_FILL;
                    end else begin
                        rdy_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_FILL;
                    valid_q <= 1'b0;
                    last_q  <= 1'b0;
                    rdy_q   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_stream_padder.sv
// Bench for sha256_stream_padder: directed and random messages compared against a byte-level
// SHA-256 padding model, plus hold-stability, reset and idle checks.
module tb_sha256_stream_padder;

    localparam int IN_W  = 32;
    localparam int WB    = IN_W / 8;
    localparam int CNT_W = 16;

    typedef logic [511:0] blk_t;

    logic               clk = 1'b0;
    logic               reset;
    logic [IN_W-1:0]    in_data;
    logic               in_valid;
    logic               in_ready;
    logic               in_last;
    logic [2:0]         in_bytes;
    logic [511:0]       out_block;
    logic               out_valid;
    logic               out_ready;
    logic               out_last;
    logic [CNT_W-1:0]   out_blk_idx;
    logic [63:0]        msg_bits;

    int total = 0;
    int bad   = 0;

    byte unsigned mbytes[$];
    blk_t         exp_q[$];
    blk_t         first_seen;

    sha256_stream_padder #(.IN_W(IN_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .in_last(in_last), .in_bytes(in_bytes),
        .out_block(out_block), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .out_blk_idx(out_blk_idx), .msg_bits(msg_bits)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input blk_t obs, input blk_t exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Standard SHA-256 padding of the whole message, split into 64-byte blocks
    task automatic build_exp();
        byte unsigned p[$];
        logic [63:0] bits;
        blk_t b;
        p = mbytes;
        bits = 64'(mbytes.size()) * 64'd8;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        for (int i = 7; i >= 0; i--) p.push_back(bits[8*i +: 8]);
        exp_q.delete();
        for (int k = 0; k < p.size() / 64; k++) begin
            b = '0;
            for (int i = 0; i < 64; i++) b[511-8*i -: 8] = p[k*64+i];
            exp_q.push_back(b);
        end
    endtask

    task automatic rand_msg(input int len);
        mbytes.delete();
        for (int i = 0; i < len; i++) mbytes.push_back(8'($urandom));
    endtask

    // mode 0: random gaps/backpressure; 1: full rate; 2: full rate, first block held 5 cycles
    task automatic run_msg(input int mode, input bit extra_empty);
        logic [IN_W-1:0] wd[$];
        logic [2:0]      wn[$];
        bit              wl[$];
        logic [IN_W-1:0] w;
        int len, nfull, rem, nw, wi, bi, cyc, hold_left;
        bit acc, prev_hold, rdy;
        blk_t held_blk;
        logic [CNT_W-1:0] held_idx;
        logic held_last;

        build_exp();
        len = mbytes.size();
        nfull = len / WB;
        rem = len % WB;
        for (int k = 0; k < nfull + ((rem != 0) ? 1 : 0); k++) begin
            for (int j = 0; j < WB; j++)
                w[IN_W-1-8*j -: 8] = (k*WB + j < len) ? mbytes[k*WB + j] : 8'($urandom);
            wd.push_back(w);
            wn.push_back((k == nfull) ? 3'(rem) : 3'(WB));
            wl.push_back(1'b0);
        end
        if (len == 0 || (rem == 0 && extra_empty)) begin
            wd.push_back(IN_W'($urandom));
            wn.push_back(3'd0);
            wl.push_back(1'b0);
        end
        nw = wd.size();
        wl[nw-1] = 1'b1;

        acc = 1'b0; prev_hold = 1'b0; wi = 0; bi = 0; cyc = 0; hold_left = 5;
        held_blk = '0; held_idx = '0; held_last = 1'b0;
        while (bi < exp_q.size() && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (acc) wi++;
            if (prev_hold) begin
                chk("hold_block", out_block, held_blk);
                chk("hold_idx", blk_t'(out_blk_idx), blk_t'(held_idx));
                chk("hold_last", blk_t'(out_last), blk_t'(held_last));
            end
            if (out_valid) chk("in_ready_while_pending", blk_t'(in_ready), blk_t'(0));
            if (mode == 0) rdy = ($urandom % 4) != 0;
            else if (mode == 2 && out_valid && hold_left > 0) begin
                rdy = 1'b0;
                hold_left--;
            end else rdy = 1'b1;
            out_ready = rdy;
            if (out_valid && rdy) begin
                chk("block", out_block, exp_q[bi]);
                chk("last", blk_t'(out_last), blk_t'(bi == exp_q.size() - 1));
                chk("idx", blk_t'(out_blk_idx), blk_t'(bi));
                if (bi == exp_q.size() - 1)
                    chk("msg_bits", blk_t'(msg_bits), blk_t'(64'(len) * 64'd8));
                if (bi == 0) first_seen = out_block;
                bi++;
            end
            prev_hold = out_valid && !rdy;
            held_blk = out_block; held_idx = out_blk_idx; held_last = out_last;
            if (wi < nw) begin
                in_valid = (mode != 0) || (($urandom % 4) != 0);
                in_data  = wd[wi];
                in_bytes = wn[wi];
                in_last  = wl[wi];
            end else begin
                in_valid = 1'b0;
            end
            acc = in_valid && in_ready;
        end
        if (bi < exp_q.size()) chk("timeout_blocks", blk_t'(bi), blk_t'(exp_q.size()));
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("idle_valid", blk_t'(out_valid), blk_t'(0));
        chk("idle_bits", blk_t'(msg_bits), blk_t'(0));
        chk("idle_idx", blk_t'(out_blk_idx), blk_t'(0));
    endtask

    initial begin
        int cnt, cyc;
        bit acc;
        blk_t abc;

        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; in_bytes = 3'd0; out_ready = 1'b0;
        first_seen = '0;
        repeat (2) @(negedge clk);
        chk("rst_valid", blk_t'(out_valid), blk_t'(0));
        chk("rst_last", blk_t'(out_last), blk_t'(0));
        chk("rst_block", out_block, blk_t'(0));
        chk("rst_idx", blk_t'(out_blk_idx), blk_t'(0));
        chk("rst_bits", blk_t'(msg_bits), blk_t'(0));
        chk("rst_ready", blk_t'(in_ready), blk_t'(0));
        reset = 1'b0;

        rand_msg(32); run_msg(1, 1'b0);
        rand_msg(0);  run_msg(1, 1'b0);
        chk("empty_block", first_seen, {8'h80, 504'd0});
        rand_msg(55); run_msg(1, 1'b0);
        rand_msg(56); run_msg(1, 1'b0);
        rand_msg(64); run_msg(1, 1'b0);
        rand_msg(64); run_msg(0, 1'b1);
        rand_msg(80); run_msg(2, 1'b0);

        // Reset while the tenth word of a 64-byte message is on the bus
        rand_msg(64);
        cnt = 0; acc = 1'b0; cyc = 0;
        while (cnt < 9 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (acc) cnt++;
            in_valid = 1'b1;
            in_last  = 1'b0;
            in_bytes = 3'(WB);
            in_data  = {mbytes[cnt*4], mbytes[cnt*4+1], mbytes[cnt*4+2], mbytes[cnt*4+3]};
            acc = in_ready;
        end
        if (cnt < 9) chk("timeout_words", blk_t'(cnt), blk_t'(9));
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid", blk_t'(out_valid), blk_t'(0));
        chk("mid_rst_bits", blk_t'(msg_bits), blk_t'(0));
        chk("mid_rst_ready", blk_t'(in_ready), blk_t'(0));
        reset = 1'b0;
        in_valid = 1'b0;

        mbytes.delete();
        mbytes.push_back(8'h61); mbytes.push_back(8'h62); mbytes.push_back(8'h63);
        run_msg(1, 1'b0);
        abc = '0;
        abc[511:480] = 32'h61626380;
        abc[63:0] = 64'd24;
        chk("abc_block", first_seen, abc);

        for (int t = 0; t < 25; t++) begin
            rand_msg(int'($urandom_range(0, 150)));
            run_msg(0, 1'($urandom % 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
